// File: rtl/cell_link_packet_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cell_link_packet_buffer
// Description : Store-and-forward packet buffer behind the cell-link
//               forwarding mux. A packet is released to the link transmitter
//               only after its TLAST word is stored. Oversize packets and
//               packets that run out of room are dropped whole.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_axis_*            input stream (tready is 1 except during reset)
//   m_axis_*            output stream, first-word-fallthrough
//   fwd_count           committed packets, wraps modulo 2**16
//   drop_count          dropped packets, saturates at 16'hFFFF
//   drop_strobe         one-cycle pulse per dropped packet
// ============================================================================
module cell_link_packet_buffer #(
    parameter int AW        = 9,
    parameter int MAX_WORDS = 64
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [15:0] fwd_count,
    output logic [15:0] drop_count,
    output logic        drop_strobe
);

    localparam logic [AW:0] C_DEPTH     = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] C_ONE       = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] C_MAX_WORDS = MAX_WORDS[AW:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state_q,    w_state_d;
    logic [AW:0] r_wr_ptr_q,   w_wr_ptr_d;    // speculative write pointer
    logic [AW:0] r_cm_ptr_q,   w_cm_ptr_d;    // end of last committed packet
    logic [AW:0] r_rd_ptr_q,   w_rd_ptr_d;
    logic [AW:0] r_wcnt_q,     w_wcnt_d;      // words of the packet in progress
    logic [15:0] r_fwd_q,      w_fwd_d;
    logic [15:0] r_drop_q,     w_drop_d;
    logic        r_strobe_q,   w_strobe_d;
    logic        r_out_vld_q,  w_out_vld_d;
    logic [32:0] r_out_word_q, w_out_word_d;  // {tlast, tdata} on m_axis

    logic [32:0] r_mem [0:(1<<AW)-1];

    logic        w_beat;
    logic        w_we;
    logic        w_rd_en;
    logic        w_full;
    logic        w_drop_evt;
    logic [AW:0] w_used;

    assign s_axis_tready = ~areset;
    assign w_beat        = s_axis_tvalid & s_axis_tready;

    // Occupancy from registered pointers only; the word sitting in the output
    // register has already left the RAM and no longer occupies a slot.
    assign w_used = r_wr_ptr_q - r_rd_ptr_q;
    assign w_full = (w_used == C_DEPTH);

    // Reads stop at cm_ptr, so a packet still being written is never visible.
    assign w_rd_en = (r_rd_ptr_q != r_cm_ptr_q) && (!r_out_vld_q || m_axis_tready);

    // ---------------- write side ----------------
    always_comb begin
        w_state_d  = r_state_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_cm_ptr_d = r_cm_ptr_q;
        w_wcnt_d   = r_wcnt_q;
        w_fwd_d    = r_fwd_q;
        w_we       = 1'b0;
        w_drop_evt = 1'b0;
        case (r_state_q)
            S_IDLE, S_FILL: begin
                if (w_beat) begin
                    if (w_full || (r_wcnt_q == C_MAX_WORDS)) begin
                        // Rewind to discard the partial packet already written.
                        w_wr_ptr_d = r_cm_ptr_q;
                        if (s_axis_tlast) begin
                            w_drop_evt = 1'b1;
                            w_wcnt_d   = '0;
                            w_state_d  = S_IDLE;
                        end else begin
                            w_state_d  = S_DROP;
                        end
                    end else begin
                        w_we       = 1'b1;
                        w_wr_ptr_d = r_wr_ptr_q + C_ONE;
                        w_wcnt_d   = r_wcnt_q + C_ONE;
                        if (s_axis_tlast) begin
                            w_cm_ptr_d = r_wr_ptr_q + C_ONE;
                            w_fwd_d    = r_fwd_q + 16'd1;
                            w_wcnt_d   = '0;
                            w_state_d  = S_IDLE;
                        end else begin
                            w_state_d  = S_FILL;
                        end
                    end
                end
            end
            S_DROP: begin
                if (w_beat && s_axis_tlast) begin
                    w_drop_evt = 1'b1;
                    w_wcnt_d   = '0;
                    w_state_d  = S_IDLE;
                end
            end
            default: begin
                w_state_d  = S_IDLE;
                w_wr_ptr_d = r_cm_ptr_q;
                w_wcnt_d   = '0;
            end
        endcase

        w_strobe_d = w_drop_evt;
        w_drop_d   = (w_drop_evt && (r_drop_q != 16'hFFFF)) ? r_drop_q + 16'd1 : r_drop_q;
    end

    // ---------------- read side ----------------
    always_comb begin
        w_rd_ptr_d   = r_rd_ptr_q;
        w_out_vld_d  = r_out_vld_q;
        w_out_word_d = r_out_word_q;
        if (w_rd_en) begin
            w_rd_ptr_d   = r_rd_ptr_q + C_ONE;
            w_out_vld_d  = 1'b1;
            w_out_word_d = r_mem[r_rd_ptr_q[AW-1:0]];
        end else if (m_axis_tready) begin
            w_out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            r_mem[r_wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q    <= S_IDLE;
            r_wr_ptr_q   <= '0;
            r_cm_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_wcnt_q     <= '0;
            r_fwd_q      <= '0;
            r_drop_q     <= '0;
            r_strobe_q   <= 1'b0;
            r_out_vld_q  <= 1'b0;
            r_out_word_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_cm_ptr_q   <= w_cm_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_wcnt_q     <= w_wcnt_d;
            r_fwd_q      <= w_fwd_d;
            r_drop_q     <= w_drop_d;
            r_strobe_q   <= w_strobe_d;
            r_out_vld_q  <= w_out_vld_d;
            r_out_word_q <= w_out_word_d;
        end
    end

    // Status and valid are forced low while reset is held, including the
    // first reset cycle before the registers have been cleared.
    assign m_axis_tvalid = r_out_vld_q & ~areset;
    assign m_axis_tdata  = r_out_word_q[31:0];
    assign m_axis_tlast  = r_out_word_q[32];
    assign fwd_count     = areset ? 16'd0 : r_fwd_q;
    assign drop_count    = areset ? 16'd0 : r_drop_q;
    assign drop_strobe   = r_strobe_q & ~areset;

endmodule
`default_nettype wire

// File: tb/tb_cell_link_packet_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_link_packet_buffer
// Description : Self-checking bench for cell_link_packet_buffer. A large
//               instance (AW=9, MAX_WORDS=64) carries the stream tests; a
//               small instance (AW=4, MAX_WORDS=8) exercises the full case.
//               Expected words come from a packet-level scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_link_packet_buffer;

    localparam int AW      = 9;
    localparam int DEPTH   = 1 << AW;
    localparam int MAX_W   = 64;
    localparam int AW_S    = 4;
    localparam int MAX_S   = 8;

    logic        aclk;
    logic        areset, areset_s;

    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [15:0] fwd_count, drop_count;
    logic        drop_strobe;

    logic        s_tvalid_s, s_tready_s, s_tlast_s;
    logic [31:0] s_tdata_s;
    logic        m_tvalid_s, m_tready_s, m_tlast_s;
    logic [31:0] m_tdata_s;
    logic [15:0] fwd_count_s, drop_count_s;
    logic        drop_strobe_s;

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          rdy_mode  = 1;   // 0: hold low, 1: hold high, 2: random
    int          fwd_exp   = 0;
    int          drop_exp  = 0;
    int          strobe_seen = 0;
    bit          mid_pkt   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp3[$];

    cell_link_packet_buffer #(.AW(AW), .MAX_WORDS(MAX_W)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .fwd_count(fwd_count), .drop_count(drop_count), .drop_strobe(drop_strobe)
    );

    cell_link_packet_buffer #(.AW(AW_S), .MAX_WORDS(MAX_S)) dut_s (
        .aclk(aclk), .areset(areset_s),
        .s_axis_tvalid(s_tvalid_s), .s_axis_tready(s_tready_s),
        .s_axis_tdata(s_tdata_s), .s_axis_tlast(s_tlast_s),
        .m_axis_tvalid(m_tvalid_s), .m_axis_tready(m_tready_s),
        .m_axis_tdata(m_tdata_s), .m_axis_tlast(m_tlast_s),
        .fwd_count(fwd_count_s), .drop_count(drop_count_s), .drop_strobe(drop_strobe_s)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready generator.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: every accepted word must be the next scoreboard word,
    // and a packet once started must not stall while the sink is ready.
    initial begin
        forever begin
            @(negedge aclk);
            if (areset) begin
                mid_pkt = 0;
            end else begin
                if (drop_strobe) strobe_seen++;
                if (mid_pkt && m_tready) check_eq("no_gap", 64'(m_tvalid), 64'd1);
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("stray_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        check_eq("out_word", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
                    end
                    mid_pkt = !m_tlast;
                end
            end
        end
    end

    // Sends one packet. The model: a packet is forwarded iff its length does
    // not exceed MAX_W; the bench waits for enough room so capacity never
    // causes a drop on the large instance.
    task automatic send_pkt(input int len, input bit rnd_gap);
        logic [32:0] words[$];
        logic [31:0] d;
        int          waits;
        waits = 0;
        while ((exp_q.size() + len > DEPTH - 1) && (waits < 20000)) begin
            @(posedge aclk); #1;
            waits++;
        end
        if (waits >= 20000) check_eq("room_timeout", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < len; i++) begin
            d = $urandom();
            s_tvalid = 1'b1;
            s_tdata  = d;
            s_tlast  = (i == len - 1);
            words.push_back({s_tlast, d});
            @(posedge aclk); #1;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            if (i == len - 1) begin
                if (len <= MAX_W) begin
                    foreach (words[j]) exp_q.push_back(words[j]);
                    fwd_exp++;
                end else if (drop_exp < 65535) begin
                    drop_exp++;
                end
            end
            if (rnd_gap && ($urandom_range(0, 3) == 0)) begin
                @(posedge aclk); #1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 20000)) begin
            @(posedge aclk);
            n++;
        end
        check_eq("drain_done", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_fwd"},    64'(fwd_count),  64'(16'(fwd_exp)));
        check_eq({tag, "_drop"},   64'(drop_count), 64'(16'(drop_exp)));
        check_eq({tag, "_strobe"}, 64'(strobe_seen), 64'(drop_exp));
    endtask

    initial begin
        logic [31:0] d;
        int          len;
        int          k;

        areset = 1'b1; areset_s = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        s_tvalid_s = 1'b0; s_tdata_s = '0; s_tlast_s = 1'b0;
        m_tready_s = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_tvalid", 64'(m_tvalid),    64'd0);
        check_eq("rst_tready", 64'(s_tready),    64'd0);
        check_eq("rst_fwd",    64'(fwd_count),   64'd0);
        check_eq("rst_drop",   64'(drop_count),  64'd0);
        check_eq("rst_strobe", 64'(drop_strobe), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0; areset_s = 1'b0;
        @(posedge aclk); #1;
        check_eq("tready_after_rst", 64'(s_tready), 64'd1);

        // T1: 4-word packet, 2-cycle first-word latency
        send_pkt(4, 0);
        @(negedge aclk);
        check_eq("t1_lat_cycle1", 64'(m_tvalid), 64'd0);
        @(negedge aclk);
        check_eq("t1_lat_cycle2", 64'(m_tvalid), 64'd1);
        check_eq("t1_first_last", 64'(m_tlast),  64'd0);
        drain();
        check_counts("t1");

        // T2: oversize packet dropped, following packet intact
        send_pkt(MAX_W + 1, 0);
        send_pkt(2, 0);
        drain();
        check_counts("t2");

        // T3: small instance fills up while the sink is stalled
        for (int p = 0; p < 4; p++) begin
            len = (p < 3) ? 5 : 4;
            for (int i = 0; i < len; i++) begin
                d = $urandom();
                s_tvalid_s = 1'b1;
                s_tdata_s  = d;
                s_tlast_s  = (i == len - 1);
                // 15 words committed, one in the output register: 14 occupy
                // the 16-slot RAM, so a 4-word packet cannot fit.
                if (p < 3) exp3.push_back({s_tlast_s, d});
                @(posedge aclk); #1;
            end
        end
        s_tvalid_s = 1'b0; s_tlast_s = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_eq("t3_fwd",        64'(fwd_count_s),  64'd3);
        check_eq("t3_drop",       64'(drop_count_s), 64'd1);
        check_eq("t3_hold_valid", 64'(m_tvalid_s),   64'd1);
        check_eq("t3_hold_word",  64'({m_tlast_s, m_tdata_s}), 64'(exp3[0]));
        m_tready_s = 1'b1;
        k = 0;
        repeat (40) begin
            @(negedge aclk);
            if (m_tvalid_s) begin
                if (k < exp3.size()) check_eq("t3_word", 64'({m_tlast_s, m_tdata_s}), 64'(exp3[k]));
                else                 check_eq("t3_extra_words", 64'(k), 64'(exp3.size()));
                k++;
            end
        end
        check_eq("t3_count", 64'(k), 64'd15);

        // T4: 100 random packets against a random 50% sink
        rdy_mode = 2;
        for (int p = 0; p < 100; p++) send_pkt($urandom_range(1, MAX_W), 1);
        rdy_mode = 1;
        drain();
        check_counts("t4");

        // T5: reset mid-packet and mid-read
        rdy_mode = 0;
        repeat (2) @(posedge aclk);
        #1;
        send_pkt(20, 0);
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1; s_tdata = $urandom(); s_tlast = 1'b0;
            @(posedge aclk); #1;
        end
        rdy_mode = 1;
        repeat (4) @(posedge aclk);
        #1;
        areset = 1'b1;
        s_tvalid = 1'b0;
        exp_q.delete();
        @(negedge aclk);
        check_eq("t5_rst_tvalid", 64'(m_tvalid),   64'd0);
        check_eq("t5_rst_tready", 64'(s_tready),   64'd0);
        check_eq("t5_rst_fwd",    64'(fwd_count),  64'd0);
        check_eq("t5_rst_drop",   64'(drop_count), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        fwd_exp = 0; drop_exp = 0; strobe_seen = 0;
        @(negedge aclk);
        check_eq("t5_post_tvalid", 64'(m_tvalid),  64'd0);
        check_eq("t5_post_fwd",    64'(fwd_count), 64'd0);
        repeat (10) @(posedge aclk);
        #1;
        send_pkt(3, 0);
        drain();
        check_counts("t5");

        // T6: 1-word packets every cycle, pointers wrap
        for (int p = 0; p < DEPTH + 10; p++) send_pkt(1, 0);
        drain();
        check_counts("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
